accum_addr_gen: RTL and testbench
=================================

Name: accum_addr_gen

Overview:
- Upstream address sequencer for the accumulator write path.
- Accepts one tile command (base row, row count, accumulate flag) and tracks systolic-array output rows as they emerge from column 0.
- Produces per-row write enable and modulo-ACCUM_ROW address, which the accumulator write-skew controller fans out across columns.
- Signals completion once the column skew has drained.

Parameters:
SYS_COL, 16, systolic array columns; sets drain length.
ACCUM_ROW, 256, accumulator depth in rows; need not be a power of two.
LEN_WIDTH, 16, width of row-count field.
ADDR_WIDTH, $clog2(ACCUM_ROW), localparam.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  tile command valid
cmd_ready  output  1  block can accept command
cmd_base_addr  input  ADDR_WIDTH  first accumulator row, must be < ACCUM_ROW
cmd_num_rows  input  LEN_WIDTH  rows in tile
cmd_accumulate  input  1  1 = add into accumulator, 0 = overwrite
sys_out_valid  input  1  column-0 output row valid this cycle
wr_en_out  output  1  write enable for column 0 of skew controller
wr_addr_out  output  ADDR_WIDTH  write address for column 0
wr_acc_out  output  1  latched cmd_accumulate, held for whole tile
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, tile fully written
err_stray  output  1  sticky: sys_out_valid seen outside RUN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state IDLE; cmd_ready 0 while rst is high; wr_en_out 0; wr_addr_out 0; wr_acc_out 0; busy 0; done 0; err_stray 0; all counters 0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready = 1 when rst is low.
  - On cmd_valid & cmd_ready: latch base, num_rows and accumulate.
  - num_rows == 0: stay IDLE, pulse done on the next cycle, issue no writes.
  - Otherwise: go to RUN with cur_addr = base and row_cnt = 0.
- RUN:
  - cmd_ready = 0.
  - wr_en_out = sys_out_valid, combinational, zero latency.
  - wr_addr_out = cur_addr (registered).
  - On each sys_out_valid: row_cnt += 1; cur_addr = (cur_addr == ACCUM_ROW-1) ? 0 : cur_addr+1.
  - Gap cycles (valid low): no advance, wr_en_out 0.
  - Valid on the row where row_cnt == num_rows-1: go to DRAIN.
- DRAIN:
  - Covers skew latency; cmd_ready = 0; wr_en_out = 0.
  - If the final write is in cycle T, done = 1 in cycle T+SYS_COL only, and the state returns to IDLE in that same cycle (cmd_ready = 1 at T+SYS_COL).
  - SYS_COL == 1: done at T+1.
- wr_addr_out holds cur_addr when not writing; wr_acc_out holds the last latched value in IDLE.
- sys_out_valid in IDLE or DRAIN: ignored (wr_en_out 0) and err_stray set; err_stray clears only on rst.
- cmd_valid while busy: not accepted, and the command fields are not sampled.
- Address arithmetic: explicit compare-and-wrap, never a bare truncating add, so non-power-of-two ACCUM_ROW wraps correctly.
- row_cnt is LEN_WIDTH wide; a command with num_rows = 2^LEN_WIDTH-1 completes without overflow.
- rst asserted mid-RUN/DRAIN: immediate return to reset values, no done pulse, and the partial tile is abandoned. The next command starts fresh.

Test Plan:
1. ACCUM_ROW=256, SYS_COL=16: base=10, rows=4, accept at cycle 1, valid cycles 3-6 -> wr_en_out high cycles 3-6, addrs 10,11,12,13, wr_acc_out=cmd_accumulate, done only at cycle 22, cmd_ready low cycles 2-21.
2. Wrap: base=254, rows=4, continuous valid -> addrs 254,255,0,1. Repeat with ACCUM_ROW=200, base=198 -> 198,199,0,1.
3. Gapped input: rows=3, base=5, valid pattern 1,0,0,1,0,1 -> writes only on valid cycles, addrs 5,6,7, done 16 cycles after the last valid.
4. Zero rows: rows=0 accepted at cycle 1 -> no wr_en_out, done at cycle 2, busy stays 0, cmd_ready stays 1.
5. Protocol errors: sys_out_valid in IDLE -> err_stray=1 and wr_en_out=0. cmd_valid during RUN with different base -> not accepted, and the current tile's addresses are unaffected.
6. Reset mid-tile: rst pulse after 2 of 8 rows -> outputs reset asynchronously, no done. A new command (base=100, rows=2) then yields addrs 100,101 and done.

Source files
------------

// File: rtl/accum_addr_gen.sv
// Accumulator write-path address sequencer.
// Tracks column-0 output rows of a tile and signals done after skew drain.
module accum_addr_gen #(
    parameter  int SYS_COL    = 16,
    parameter  int ACCUM_ROW  = 256,
    parameter  int LEN_WIDTH  = 16,
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_num_rows,
    input  logic                  cmd_accumulate,
    input  logic                  sys_out_valid,
    output logic                  wr_en_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic                  wr_acc_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err_stray
);

    // DRAIN lasts SYS_COL-1 cycles; done lands on the cycle IDLE is re-entered.
    localparam int DCW        = (SYS_COL > 2) ? $clog2(SYS_COL) : 1;
    localparam int DRAIN_LAST = (SYS_COL >= 2) ? SYS_COL - 2 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [LEN_WIDTH-1:0]  r_num_rows;
    logic [LEN_WIDTH-1:0]  r_row_cnt;
    logic [DCW-1:0]        r_drain_cnt;
    logic                  r_acc;
    logic                  r_done;
    logic                  r_err;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_fire;
    logic                  w_done_nxt;

    assign w_ready     = (r_state == S_IDLE) && !rst;
    assign cmd_ready   = w_ready;
    assign wr_en_out   = w_fire;
    assign wr_addr_out = r_cur_addr;
    assign wr_acc_out  = r_acc;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign err_stray   = r_err;

    // Compare-and-wrap so non-power-of-two depths wrap at ACCUM_ROW.
    assign w_addr_inc = (r_cur_addr == ADDR_WIDTH'(ACCUM_ROW - 1))
                      ? '0 : r_cur_addr + ADDR_WIDTH'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, accept/fire strobes and done request.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_fire     = 1'b0;
        w_done_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid && w_ready) begin
                    w_accept = 1'b1;
                    if (cmd_num_rows == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (sys_out_valid) begin
                    w_fire = 1'b1;
                    if (r_row_cnt == r_num_rows - LEN_WIDTH'(1)) begin
                        w_next     = (SYS_COL == 1) ? S_IDLE : S_DRAIN;
                        w_done_nxt = (SYS_COL == 1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == DCW'(DRAIN_LAST)) begin
                    w_next     = S_IDLE;
                    w_done_nxt = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Command latch, row/address counters, drain timer and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_addr  <= '0;
            r_num_rows  <= '0;
            r_row_cnt   <= '0;
            r_drain_cnt <= '0;
            r_acc       <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (sys_out_valid && (r_state != S_RUN)) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_cur_addr <= cmd_base_addr;
                r_num_rows <= cmd_num_rows;
                r_acc      <= cmd_accumulate;
                r_row_cnt  <= '0;
            end else if (w_fire) begin
                r_cur_addr <= w_addr_inc;
                r_row_cnt  <= r_row_cnt + LEN_WIDTH'(1);
            end
            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + DCW'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_accum_addr_gen.sv
// Self-checking bench for accum_addr_gen: vector table plus corner sequences.
// A scoreboard queue holds expected writes; a negedge monitor pops them.
module tb_accum_addr_gen;

    localparam int SC = 16;
    localparam int AR = 256;
    localparam int LW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base_addr = '0;
    logic [LW-1:0] cmd_num_rows = '0;
    logic          cmd_accumulate = 1'b0;
    logic          sys_out_valid = 1'b0;
    logic          wr_en_out;
    logic [AW-1:0] wr_addr_out;
    logic          wr_acc_out;
    logic          busy;
    logic          done;
    logic          err_stray;

    logic          b_cmd_valid = 1'b0;
    logic          b_cmd_ready;
    logic [7:0]    b_base = '0;
    logic [LW-1:0] b_rows = '0;
    logic          b_acc = 1'b0;
    logic          b_sys = 1'b0;
    logic          b_wr_en;
    logic [7:0]    b_wr_addr;
    logic          b_wr_acc;
    logic          b_busy;
    logic          b_done;
    logic          b_err;

    accum_addr_gen #(.SYS_COL(SC), .ACCUM_ROW(AR), .LEN_WIDTH(LW)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_num_rows(cmd_num_rows),
        .cmd_accumulate(cmd_accumulate), .sys_out_valid(sys_out_valid),
        .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
        .wr_acc_out(wr_acc_out), .busy(busy), .done(done),
        .err_stray(err_stray)
    );

    accum_addr_gen #(.SYS_COL(1), .ACCUM_ROW(200), .LEN_WIDTH(LW)) u_dut200 (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_base_addr(b_base), .cmd_num_rows(b_rows),
        .cmd_accumulate(b_acc), .sys_out_valid(b_sys),
        .wr_en_out(b_wr_en), .wr_addr_out(b_wr_addr),
        .wr_acc_out(b_wr_acc), .busy(b_busy), .done(b_done),
        .err_stray(b_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic          acc;
    } wr_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] rows;
        logic          acc;
        logic [31:0]   pat;
        bit            intr;
        logic [AW-1:0] e_first;
        logic [AW-1:0] e_last;
    } vec_t;

    wr_t           q[$];
    vec_t          tab[7];
    int            n_vec = 0;
    int            n_bad = 0;
    int            n_wr = 0;
    int            n_done = 0;
    logic [AW-1:0] first_a = '0;
    logic [AW-1:0] last_a = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && done) n_done++;
        if (!rst && wr_en_out) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: addr %0d", wr_addr_out);
            end else begin
                e = q.pop_front();
                if (wr_addr_out !== e.a || wr_acc_out !== e.acc) begin
                    n_bad++;
                    $display("FAIL write: got addr %0d acc %0b, expected addr %0d acc %0b",
                             wr_addr_out, wr_acc_out, e.a, e.acc);
                end
            end
            if (n_wr == 0) first_a = wr_addr_out;
            last_a = wr_addr_out;
            n_wr++;
        end
    end

    task automatic run_tile(input vec_t v);
        logic [AW-1:0] ea;
        logic          sv;
        int            sent;
        int            idx;
        int            got;
        n_wr = 0;
        cmd_valid      = 1'b1;
        cmd_base_addr  = v.base;
        cmd_num_rows   = v.rows;
        cmd_accumulate = v.acc;
        @(negedge clk);
        chk("accept_ready", cmd_ready, 1);
        tick();
        cmd_valid      = 1'b0;
        cmd_base_addr  = 8'hAA;
        cmd_num_rows   = 16'd9;
        cmd_accumulate = ~v.acc;
        if (v.rows == 0) begin
            @(negedge clk);
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            chk("zero_ready", cmd_ready, 1);
            tick();
            @(negedge clk);
            chk("zero_done_clear", done, 0);
            tick();
            chk("zero_writes", n_wr, 0);
            return;
        end
        ea = v.base;
        sent = 0;
        idx = 0;
        while (sent < int'(v.rows)) begin
            sv = (idx < 32) ? v.pat[idx] : 1'b1;
            sys_out_valid = sv;
            if (v.intr && sent == 1) begin
                cmd_valid      = 1'b1;
                cmd_base_addr  = v.base + 8'd77;
                cmd_num_rows   = '0;
                cmd_accumulate = ~v.acc;
            end
            if (sv) begin
                q.push_back('{ea, v.acc});
                ea = (int'(ea) == AR - 1) ? '0 : ea + 8'd1;
                sent++;
            end
            @(negedge clk);
            chk("run_ready", cmd_ready, 0);
            chk("run_wr_en", wr_en_out, sv);
            tick();
            idx++;
        end
        sys_out_valid = 1'b0;
        cmd_valid = 1'b0;
        got = 0;
        for (int k = 1; k <= SC + 4 && got == 0; k++) begin
            @(negedge clk);
            if (done) begin
                got = k;
                chk("done_ready", cmd_ready, 1);
                chk("done_busy", busy, 0);
            end else begin
                chk("drain_ready", cmd_ready, 0);
                chk("drain_wr_en", wr_en_out, 0);
            end
            tick();
        end
        chk("done_latency", got, SC);
        @(negedge clk);
        chk("done_clear", done, 0);
        tick();
        chk("n_writes", n_wr, v.rows);
        chk("first_addr", first_a, v.e_first);
        chk("last_addr", last_a, v.e_last);
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        logic [7:0] e200 [4];
        int         dn;
        e200 = '{8'd198, 8'd199, 8'd0, 8'd1};
        tab[0] = '{8'd10,  16'd4,   1'b1, 32'hFFFF_FFFE, 1'b0, 8'd10,  8'd13};
        tab[1] = '{8'd254, 16'd4,   1'b0, 32'hFFFF_FFFF, 1'b0, 8'd254, 8'd1};
        tab[2] = '{8'd5,   16'd3,   1'b1, 32'h0000_0029, 1'b0, 8'd5,   8'd7};
        tab[3] = '{8'd33,  16'd0,   1'b1, 32'hFFFF_FFFF, 1'b0, 8'd0,   8'd0};
        tab[4] = '{8'd250, 16'd300, 1'b1, 32'h5555_5555, 1'b0, 8'd250, 8'd37};
        tab[5] = '{8'd255, 16'd1,   1'b0, 32'hFFFF_FFFF, 1'b0, 8'd255, 8'd255};
        tab[6] = '{8'd40,  16'd4,   1'b1, 32'hFFFF_FFFF, 1'b1, 8'd40,  8'd43};

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_wr_en", wr_en_out, 0);
        chk("rst_addr", wr_addr_out, 0);
        chk("rst_acc", wr_acc_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_stray, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_tile(tab[i]);

        // Stray valid in IDLE: no write, sticky error.
        sys_out_valid = 1'b1;
        @(negedge clk);
        chk("stray_wr_en", wr_en_out, 0);
        tick();
        sys_out_valid = 1'b0;
        @(negedge clk);
        chk("stray_err", err_stray, 1);
        tick();
        repeat (3) tick();
        chk("stray_err_sticky", err_stray, 1);

        // Reset mid-tile after 2 of 8 rows.
        n_wr = 0;
        cmd_valid = 1'b1;
        cmd_base_addr = 8'd60;
        cmd_num_rows = 16'd8;
        cmd_accumulate = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sys_out_valid = 1'b1;
            q.push_back('{8'(60 + i), 1'b1});
            tick();
        end
        sys_out_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("amid_busy", busy, 0);
        chk("amid_addr", wr_addr_out, 0);
        chk("amid_acc", wr_acc_out, 0);
        chk("amid_wr_en", wr_en_out, 0);
        chk("amid_err", err_stray, 0);
        chk("amid_ready", cmd_ready, 0);
        tick();
        rst = 1'b0;
        dn = n_done;
        repeat (SC + 4) tick();
        chk("amid_no_done", n_done - dn, 0);
        chk("amid_partial_writes", n_wr, 2);
        run_tile('{8'd100, 16'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'd100, 8'd101});

        // ACCUM_ROW=200, SYS_COL=1: non-power-of-two wrap, done at T+1.
        b_cmd_valid = 1'b1;
        b_base = 8'd198;
        b_rows = 16'd4;
        b_acc = 1'b1;
        @(negedge clk);
        chk("b_ready", b_cmd_ready, 1);
        tick();
        b_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_sys = 1'b1;
            @(negedge clk);
            chk("b_wr_en", b_wr_en, 1);
            chk("b_addr", b_wr_addr, e200[i]);
            chk("b_acc", b_wr_acc, 1);
            tick();
        end
        b_sys = 1'b0;
        @(negedge clk);
        chk("b_done", b_done, 1);
        chk("b_busy", b_busy, 0);
        chk("b_ready_back", b_cmd_ready, 1);
        tick();
        @(negedge clk);
        chk("b_done_clear", b_done, 0);
        chk("b_err", b_err, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
